// File: rtl/logic_op_pipe_if.sv
// Producer/consumer handshake bundle for logic_op_pipe: the operand side on
// in_*, and the registered result plus reduction flags on out_*.
interface logic_op_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_red_and;
  logic             out_red_or;
  logic             out_red_xor;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, out_ready,
    input  in_ready, out_valid, out_res, out_red_and, out_red_or,
           out_red_xor, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, out_ready,
    output in_ready, out_valid, out_res, out_red_and, out_red_or,
           out_red_xor, out_zero
  );
endinterface

// File: rtl/logic_op_pipe.sv
// One-stage bitwise operation pipeline with valid/ready handshake, registered
// reduction flags, a folding accumulator and a wrapping transfer counter.
module logic_op_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_op_pipe_if.slave       bus,
  input  logic                 acc_clr,
  output logic [WIDTH-1:0]     acc_q,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  logic             out_valid_q;
  logic [WIDTH-1:0] res_q;
  logic             red_and_q;
  logic             red_or_q;
  logic             red_xor_q;
  logic             zero_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] res_d;
  op_e              op;

  // Ready depends only on the output register state, never on in_valid.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign op           = op_e'(bus.in_op);

  always_comb begin
    a_eff = bus.in_a;
    if (bus.in_acc) begin
      a_eff = acc_clr ? '0 : acc_q;
    end
  end

  always_comb begin
    res_d = a_eff;
    case (op)
      OP_AND:  res_d = a_eff & bus.in_b;
      OP_OR:   res_d = a_eff | bus.in_b;
      OP_XOR:  res_d = a_eff ^ bus.in_b;
      OP_NAND: res_d = ~(a_eff & bus.in_b);
      OP_NOR:  res_d = ~(a_eff | bus.in_b);
      OP_XNOR: res_d = ~(a_eff ^ bus.in_b);
      OP_PASS: res_d = a_eff;
      OP_NOT:  res_d = ~a_eff;
      default: res_d = a_eff;
    endcase
  end

  // Flags are loaded from res_d alongside res_q so they can never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      red_and_q   <= 1'b0;
      red_or_q    <= 1'b0;
      red_xor_q   <= 1'b0;
      zero_q      <= 1'b1;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      res_q       <= res_d;
      red_and_q   <= &res_d;
      red_or_q    <= |res_d;
      red_xor_q   <= ^res_d;
      zero_q      <= (res_d == '0);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= res_d;
    end else if (acc_clr) begin
      acc_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_res     = res_q;
  assign bus.out_red_and = red_and_q;
  assign bus.out_red_or  = red_or_q;
  assign bus.out_red_xor = red_xor_q;
  assign bus.out_zero    = zero_q;
  assign op_count        = cnt_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe (WIDTH=8, CNT_W=4) against a
// transaction-level reference model.
module tb_logic_op_pipe;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;

  logic         clk;
  logic         rst_n;
  logic         acc_clr;
  logic [W-1:0] acc_q;
  logic [C-1:0] op_count;

  logic_op_pipe_if #(.WIDTH(W)) bus ();

  logic_op_pipe #(.WIDTH(W), .CNT_W(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .acc_clr  (acc_clr),
    .acc_q    (acc_q),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic         m_valid;
  logic [W-1:0] m_res;
  logic [W-1:0] m_acc;
  int           m_cnt;

  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return ~(a ^ b);
      6: return a;
      default: return ~a;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_res   = '0;
    m_acc   = '0;
    m_cnt   = 0;
  endtask

  // Advance the model with the inputs presently driven, then cross one edge.
  task automatic tick();
    logic         rdy;
    logic [W-1:0] a;
    rdy = !m_valid || bus.out_ready;
    if (bus.in_valid && rdy) begin
      a = bus.in_acc ? (acc_clr ? '0 : m_acc) : bus.in_a;
      m_res   = ref_op(int'(bus.in_op), a, bus.in_b);
      m_valid = 1'b1;
      m_acc   = m_res;
      m_cnt   = (m_cnt + 1) % (1 << C);
    end else begin
      if (m_valid && bus.out_ready) m_valid = 1'b0;
      if (acc_clr) m_acc = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int op, input logic use_acc, input logic clr);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = 3'(op);
    bus.in_acc   = use_acc;
    acc_clr      = clr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, 0, 1'b0, 1'b0);
    model_reset();
    #12;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", bus.out_valid); end
    total++; if (bus.out_res !== 8'h00) begin bad++; $display("FAIL reset_res got=%0h exp=00", bus.out_res); end
    total++; if ({bus.out_zero, bus.out_red_and, bus.out_red_or, bus.out_red_xor} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags got=%b exp=1000",
                      {bus.out_zero, bus.out_red_and, bus.out_red_or, bus.out_red_xor});
    end
    total++; if (acc_q !== 8'h00) begin bad++; $display("FAIL reset_acc got=%0h exp=00", acc_q); end
    total++; if (op_count !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", op_count); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_opcode_sweep();
    logic [W-1:0] exp_tab [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0, 8'h0F};
    bus.out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      drive(1'b1, 8'hF0, 8'hCC, op, 1'b0, 1'b0);
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_res !== exp_tab[op]) begin
        bad++; $display("FAIL sweep_op%0d got=%0h/%0h exp=1/%0h", op, bus.out_valid, bus.out_res, exp_tab[op]);
      end
    end
    total++; if (op_count !== 4'd8) begin bad++; $display("FAIL sweep_cnt got=%0d exp=8", op_count); end
    drive(1'b0, '0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_accumulate();
    logic [W-1:0] bs   [4] = '{8'h01, 8'h02, 8'h04, 8'h80};
    logic [W-1:0] exps [4] = '{8'h01, 8'h03, 8'h07, 8'h87};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h55, bs[i], 1, 1'b1, (i == 0));
      tick();
      total++; if (bus.out_res !== exps[i]) begin
        bad++; $display("FAIL accum_step%0d got=%0h exp=%0h", i, bus.out_res, exps[i]);
      end
    end
    total++; if (acc_q !== 8'h87) begin bad++; $display("FAIL accum_acc got=%0h exp=87", acc_q); end
    total++; if (bus.out_red_xor !== 1'b0 || bus.out_red_or !== 1'b1) begin
      bad++; $display("FAIL accum_flags got=xor%b or%b exp=xor0 or1", bus.out_red_xor, bus.out_red_or);
    end
    drive(1'b0, '0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midstream();
    // out_valid=1 and acc_q=0x87 left by test_accumulate
    #3 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || acc_q !== 8'h00) begin
      bad++; $display("FAIL async_reset got=valid%b acc%0h exp=valid0 acc00", bus.out_valid, acc_q);
    end
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [C-1:0] cnt0;
    bus.out_ready = 1'b0;
    drive(1'b1, 8'hAA, 8'hFF, 0, 1'b0, 1'b0);
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_res !== 8'hAA || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_first got=v%b r%0h rdy%b exp=v1 rAA rdy0", bus.out_valid, bus.out_res, bus.in_ready);
    end
    cnt0 = op_count;
    drive(1'b1, 8'h0F, 8'h00, 6, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_res !== 8'hAA || bus.in_ready !== 1'b0 ||
                   op_count !== cnt0 || bus.out_red_xor !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got=v%b r%0h rdy%b cnt%0d exp=v1 rAA rdy0 cnt%0d",
                        i, bus.out_valid, bus.out_res, bus.in_ready, op_count, cnt0);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready got=%b exp=1", bus.in_ready); end
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_res !== 8'h0F || op_count !== C'(cnt0 + 1)) begin
      bad++; $display("FAIL bp_release got=v%b r%0h cnt%0d exp=v1 r0F cnt%0d",
                      bus.out_valid, bus.out_res, op_count, C'(cnt0 + 1));
    end
    drive(1'b0, '0, '0, 0, 1'b0, 1'b0);
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.out_res !== 8'h0F) begin
      bad++; $display("FAIL bp_drain got=v%b r%0h exp=v0 r0F", bus.out_valid, bus.out_res);
    end
  endtask

  task automatic test_flags();
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h5A, 8'h5A, 2, 1'b0, 1'b0);
    tick();
    total++; if (bus.out_res !== 8'h00 || bus.out_zero !== 1'b1 || bus.out_red_or !== 1'b0) begin
      bad++; $display("FAIL flags_xor got=r%0h z%b or%b exp=r00 z1 or0", bus.out_res, bus.out_zero, bus.out_red_or);
    end
    drive(1'b1, 8'h00, 8'h00, 4, 1'b0, 1'b0);
    tick();
    total++; if (bus.out_res !== 8'hFF || bus.out_red_and !== 1'b1 || bus.out_red_xor !== 1'b0 ||
                 bus.out_zero !== 1'b0) begin
      bad++; $display("FAIL flags_nor got=r%0h and%b xor%b z%b exp=rFF and1 xor0 z0",
                      bus.out_res, bus.out_red_and, bus.out_red_xor, bus.out_zero);
    end
    drive(1'b0, '0, '0, 0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_count_wrap();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 8'h3C, i % 8, 1'b0, 1'b0);
      tick();
      if (i == 14) begin
        total++; if (op_count !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%0d exp=15", op_count); end
      end
    end
    total++; if (op_count !== 4'd0) begin bad++; $display("FAIL wrap_0 got=%0d exp=0", op_count); end
    drive(1'b0, '0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] er;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      total++; if (bus.in_ready !== (!m_valid || bus.out_ready)) begin
        bad++; $display("FAIL rand_ready%0d got=%b exp=%b", i, bus.in_ready, (!m_valid || bus.out_ready));
      end
      tick();
      er = m_res;
      total++; if ({bus.out_valid, bus.out_res, acc_q, op_count} !== {m_valid, er, m_acc, 4'(m_cnt)} ||
                   bus.out_red_and !== (er == 8'hFF) || bus.out_red_or !== (er != 8'h00) ||
                   bus.out_zero !== (er == 8'h00) || bus.out_red_xor !== 1'($countones(er) % 2)) begin
        bad++; $display("FAIL rand_cyc%0d got=v%b r%0h acc%0h cnt%0d f%b%b%b%b exp=v%b r%0h acc%0h cnt%0d",
                        i, bus.out_valid, bus.out_res, acc_q, op_count, bus.out_red_and,
                        bus.out_red_or, bus.out_red_xor, bus.out_zero, m_valid, er, m_acc, m_cnt);
      end
    end
    drive(1'b0, '0, '0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_opcode_sweep();
    test_accumulate();
    test_reset_midstream();
    test_backpressure();
    test_flags();
    test_count_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
Parametrised, pipelined successor to the team's two-input AND/OR/XOR block. It accepts WIDTH-bit operand pairs on a valid/ready handshake, applies one of eight bitwise operations, and registers the result with reduction flags. It also provides an internal accumulator so a stream of operands can be folded into a single result. It sits between a producer and a consumer, and neither side may drop a transfer.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of accepted-transfer counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  producer has an operand set
in_ready  out  1  block can accept this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  3  opcode
in_acc  in  1  1: use accumulator as operand A instead of in_a
acc_clr  in  1  clear accumulator
out_valid  out  1  result register holds an unconsumed result
out_ready  in  1  consumer takes result
out_res  out  WIDTH  registered result
out_red_and  out  1  &out_res
out_red_or  out  1  |out_res
out_red_xor  out  1  ^out_res
out_zero  out  1  out_res == 0
acc_q  out  WIDTH  accumulator value
op_count  out  CNT_W  number of accepted transfers, wraps

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low. Everything else is synchronous to the rising edge of clk.
- Reset values: out_valid=0, out_res=0, out_red_and=0, out_red_or=0, out_red_xor=0, out_zero=1, acc_q=0, op_count=0.
- Reset may be asserted mid-operation. It discards any pending result immediately, with no handshake.
- in_ready = !out_valid || out_ready. This is combinational; there is no combinational path from in_valid to in_ready.
- Accept (transfer) occurs when in_valid && in_ready.
- Effective operand A (A_eff):
  - in_acc=0: A_eff = in_a.
  - in_acc=1, acc_clr=0: A_eff = acc_q.
  - in_acc=1, acc_clr=1: A_eff = 0.
- Opcodes, R = f(A_eff, in_b):
  - 0 AND, 1 OR, 2 XOR
  - 3 NAND, 4 NOR, 5 XNOR
  - 6 pass A_eff, 7 NOT A_eff
  - All operations are bitwise at WIDTH; there is no carry or sign extension.
- On accept, at the next edge:
  - out_res <= R and out_valid <= 1.
  - The four flags are loaded from R in the same edge, so they always match out_res.
  - acc_q <= R, regardless of in_acc.
  - op_count <= op_count+1, wrapping from 2^CNT_W-1 to 0.
- Latency is 1 cycle from accept to out_valid. Throughput is 1 transfer per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, out_res and all flags hold stable and in_ready=0.
- On a consume (out_valid && out_ready) with no accept in the same cycle, out_valid <= 0. out_res and the flags keep their last value.
- A consume and an accept in the same cycle is a legal simultaneous event: out_valid stays 1 and the new result replaces the old one.
- acc_clr without an accept: acc_q <= 0.
- acc_clr together with an accept: acc_q <= R. Clear-then-operate applies only when in_acc=1.
- in_a, in_b, in_op, in_acc are sampled only on accept. They are don't-care otherwise.

Test Plan:
- Reset: hold rst_n=0 -> out_valid=0, out_res=0x00, out_zero=1, acc_q=0, op_count=0. Then release rst_n.
- Opcode sweep: WIDTH=8, out_ready=1, a=0xF0, b=0xCC, ops 0..7 back-to-back -> out_res = 0xC0, 0xFC, 0x3C, 0x3F, 0x03, 0xC3, 0xF0, 0x0F on consecutive cycles; op_count=8.
- Accumulate: send acc_clr=1, in_acc=1, op=1, b=0x01, then in_acc=1, op=1 with b=0x02, 0x04, 0x80 -> out_res sequence 0x01, 0x03, 0x07, 0x87; acc_q=0x87; out_red_xor=0, out_red_or=1.
- Backpressure: with out_ready=0, send 0xAA AND 0xFF -> out_valid=1, out_res=0xAA, in_ready=0. Hold 5 cycles -> values stable and a second in_valid is not accepted. Raise out_ready -> the second transfer is taken in the same cycle.
- Flags: XOR 0x5A with 0x5A -> out_res=0, out_zero=1. NOR 0x00 with 0x00 -> out_res=0xFF, out_red_and=1, out_red_xor=0.
- Reset mid-stream: assert rst_n=0 asynchronously while out_valid=1 and acc_q=0x87 -> out_valid and acc_q go to 0 before the next clk edge. op_count wraps at CNT_W=4 after 16 transfers to 0.
